// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller: compares a keypad digit stream against a programmable code,
// with timed unlock window, wrong-attempt counter and timed alarm lockout.
// Optional entry idle abort is enabled by defining ENTRY_TIMEOUT_EN.
module combo_lock_ctrl #(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int LOCKOUT_CYCLES = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  // digit_valid_i is a single-cycle strobe with no back-pressure: the digit on digit_i
  // is consumed on the rising edge that samples digit_valid_i high, or dropped if the
  // current state ignores keypad input.
  input  logic [DIGIT_W-1:0]                    digit_i,
  input  logic                                  digit_valid_i,
  input  logic [N_DIGITS*DIGIT_W-1:0]           code_i,
  input  logic                                  relock_i,
  output logic [1:0]                            output_o,
  output logic [$clog2(N_DIGITS+1)-1:0]         digit_count_o,
  output logic [$clog2(MAX_TRIES+1)-1:0]        fail_count_o,
  output logic [1:0]                            state_o
);

  localparam int DC_W  = $clog2(N_DIGITS + 1);
  localparam int FC_W  = $clog2(MAX_TRIES + 1);
  localparam int T_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                         ((UNLOCK_CYCLES > TIMEOUT_CYCLES) ? UNLOCK_CYCLES : TIMEOUT_CYCLES) :
                         ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
  localparam int T_W   = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    S_ENTRY = 2'b00,
    S_ALARM = 2'b01,
    S_OPEN  = 2'b10
  } state_t;

  state_t            state_q;
  logic [DC_W-1:0]   dc_q;
  logic [FC_W-1:0]   fc_q;
  logic [T_W-1:0]    timer_q;
  logic              miss_q;

  logic [DIGIT_W-1:0] code_digit;
  logic               digit_match;
  logic               last_digit;
  logic               attempt_miss;
  int                 fail_next;

  always_comb begin
    code_digit = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (dc_q == DC_W'(k)) code_digit = code_i[k*DIGIT_W +: DIGIT_W];
    end
  end

  assign digit_match  = (digit_i == code_digit);
  assign last_digit   = (dc_q == DC_W'(N_DIGITS - 1));
  assign attempt_miss = miss_q | ~digit_match;
  assign fail_next    = int'(fc_q) + 1;

  // One timer serves the unlock window, the lockout and (when enabled) the entry idle
  // abort; the three never run at the same time, so every transition restarts it at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_ENTRY;
      dc_q    <= '0;
      fc_q    <= '0;
      timer_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (digit_valid_i) begin
            timer_q <= '0;
            if (last_digit) begin
              dc_q   <= '0;
              miss_q <= 1'b0;
              if (!attempt_miss) begin
                state_q <= S_OPEN;
                fc_q    <= '0;
              end else if (fail_next < MAX_TRIES) begin
                fc_q <= fc_q + 1'b1;
              end else begin
                state_q <= S_ALARM;
                fc_q    <= FC_W'(MAX_TRIES);
              end
            end else begin
              dc_q   <= dc_q + 1'b1;
              miss_q <= attempt_miss;
            end
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (dc_q != '0) begin
            // An abort only discards the partial entry; it is not a failed attempt.
            if (timer_q == T_W'(TIMEOUT_CYCLES - 1)) begin
              dc_q    <= '0;
              miss_q  <= 1'b0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end else begin
            timer_q <= '0;
          end
`endif
        end
        S_OPEN: begin
          if (relock_i || timer_q == T_W'(UNLOCK_CYCLES - 1)) begin
            state_q <= S_ENTRY;
            timer_q <= '0;
            dc_q    <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_ALARM: begin
          if (timer_q == T_W'(LOCKOUT_CYCLES - 1)) begin
            state_q <= S_ENTRY;
            timer_q <= '0;
            dc_q    <= '0;
            fc_q    <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_ENTRY;
          dc_q    <= '0;
          fc_q    <= '0;
          timer_q <= '0;
          miss_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    output_o = 2'b00;
    case (state_q)
      S_OPEN:  output_o = 2'b10;
      S_ALARM: output_o = 2'b01;
      default: output_o = 2'b00;
    endcase
  end

  assign state_o       = state_q;
  assign digit_count_o = dc_q;
  assign fail_count_o  = fc_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with Code=16'h4321 (entry order 1,2,3,4).
// Define ENTRY_TIMEOUT_EN to also exercise the idle abort with TIMEOUT_CYCLES=8.
module tb_combo_lock_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  digit;
  logic        digit_valid;
  logic [15:0] code;
  logic        relock;
  logic [1:0]  out_w;
  logic [2:0]  dc_w;
  logic [1:0]  fc_w;
  logic [1:0]  state_w;

  int n_checks = 0;
  int n_fail   = 0;

  combo_lock_ctrl #(
    .N_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3),
    .UNLOCK_CYCLES(16), .LOCKOUT_CYCLES(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .digit_i(digit), .digit_valid_i(digit_valid),
    .code_i(code), .relock_i(relock), .output_o(out_w), .digit_count_o(dc_w),
    .fail_count_o(fc_w), .state_o(state_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: all start and end on a falling edge
  task automatic send_digit(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic send_code(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
    send_digit(d0);
    send_digit(d1);
    send_digit(d2);
    send_digit(d3);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #1 rst = 1'b1;
    #1;
    check_eq({tag, "_out"}, 32'(out_w), 32'h0);
    check_eq({tag, "_dc"},  32'(dc_w),  32'h0);
    check_eq({tag, "_fc"},  32'(fc_w),  32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; digit = '0; digit_valid = 1'b0; relock = 1'b0; code = 16'h4321;
    wait_cycles(2);
    check_eq("reset_out", 32'(out_w), 32'h0);
    check_eq("reset_dc",  32'(dc_w),  32'h0);
    check_eq("reset_fc",  32'(fc_w),  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // correct code opens for exactly 16 cycles
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    check_eq("t1_dc3", 32'(dc_w), 32'd3);
    send_digit(4'd4);
    check_eq("t1_open",    32'(out_w), 32'h2);
    check_eq("t1_fc",      32'(fc_w),  32'h0);
    check_eq("t1_dc_open", 32'(dc_w),  32'h0);
    wait_cycles(15);
    check_eq("t1_open_last", 32'(out_w), 32'h2);
    wait_cycles(1);
    check_eq("t1_relocked", 32'(out_w), 32'h0);

    // one wrong attempt, then correct
    send_code(4'd1, 4'd2, 4'd3, 4'd5);
    check_eq("t2_out", 32'(out_w), 32'h0);
    check_eq("t2_fc",  32'(fc_w),  32'h1);
    check_eq("t2_dc",  32'(dc_w),  32'h0);
    send_code(4'd1, 4'd2, 4'd3, 4'd4);
    check_eq("t2_open", 32'(out_w), 32'h2);
    check_eq("t2_fc0",  32'(fc_w),  32'h0);
    wait_cycles(16);
    check_eq("t2_closed", 32'(out_w), 32'h0);

    // three wrong attempts (miss at last, first, middle digit) -> alarm for 32 cycles
    send_code(4'd1, 4'd2, 4'd3, 4'd5);
    check_eq("t3_fc1", 32'(fc_w), 32'h1);
    send_code(4'd9, 4'd2, 4'd3, 4'd4);
    check_eq("t3_fc2",  32'(fc_w),  32'h2);
    check_eq("t3_out0", 32'(out_w), 32'h0);
    send_code(4'd1, 4'd1, 4'd3, 4'd4);
    check_eq("t3_alarm", 32'(out_w), 32'h1);
    check_eq("t3_fc3",   32'(fc_w),  32'h3);
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    check_eq("t3_dc_ignored", 32'(dc_w),  32'h0);
    check_eq("t3_alarm_held", 32'(out_w), 32'h1);
    wait_cycles(28);
    check_eq("t3_alarm_last", 32'(out_w), 32'h1);
    wait_cycles(1);
    check_eq("t3_end_out", 32'(out_w), 32'h0);
    check_eq("t3_end_fc",  32'(fc_w),  32'h0);
    check_eq("t3_end_dc",  32'(dc_w),  32'h0);

    // relock ignored in entry; early relock in open; strobes ignored while open
    send_digit(4'd1); send_digit(4'd2);
    pulse_relock();
    check_eq("t4_entry_relock_dc", 32'(dc_w), 32'd2);
    send_digit(4'd3); send_digit(4'd4);
    check_eq("t4_open", 32'(out_w), 32'h2);
    send_digit(4'd1); send_digit(4'd2);
    check_eq("t4_open_dc", 32'(dc_w),  32'h0);
    check_eq("t4_open_2",  32'(out_w), 32'h2);
    wait_cycles(2);
    pulse_relock();
    check_eq("t4_relock_out", 32'(out_w), 32'h0);
    check_eq("t4_relock_dc",  32'(dc_w),  32'h0);

    // code changed mid-entry: each digit compares against the code of its own cycle
    send_digit(4'd1);
    code = 16'h4391;
    send_digit(4'd9); send_digit(4'd3); send_digit(4'd4);
    check_eq("code_change_open", 32'(out_w), 32'h2);
    code = 16'h4321;
    wait_cycles(16);
    check_eq("code_change_closed", 32'(out_w), 32'h0);

    // asynchronous reset mid-entry and mid-alarm
    send_digit(4'd1); send_digit(4'd2);
    check_eq("t5_dc2", 32'(dc_w), 32'd2);
    async_reset_check("t5_rst_entry");
    send_code(4'd5, 4'd5, 4'd5, 4'd5);
    send_code(4'd5, 4'd5, 4'd5, 4'd5);
    send_code(4'd5, 4'd5, 4'd5, 4'd5);
    check_eq("t5_alarm", 32'(out_w), 32'h1);
    wait_cycles(5);
    async_reset_check("t5_rst_alarm");
    send_code(4'd1, 4'd2, 4'd3, 4'd4);
    check_eq("t5_open", 32'(out_w), 32'h2);
    wait_cycles(16);
    check_eq("t5_closed", 32'(out_w), 32'h0);

`ifdef ENTRY_TIMEOUT_EN
    // idle abort after 8 cycles; a strobe in the 8th idle cycle wins over the abort
    send_digit(4'd1); send_digit(4'd2);
    wait_cycles(8);
    check_eq("t6_abort_dc", 32'(dc_w), 32'h0);
    check_eq("t6_abort_fc", 32'(fc_w), 32'h0);
    send_digit(4'd1); send_digit(4'd2);
    wait_cycles(7);
    send_digit(4'd3);
    check_eq("t6_strobe_wins", 32'(dc_w), 32'd3);
    send_digit(4'd4);
    check_eq("t6_open", 32'(out_w), 32'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
